decode_stage: RTL and testbench

//  Instruction decode stage with ID/EX output register: sits between fetch and the ALU/execute stage.

---
 rtl/decode_stage.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32 instruction decode with an ID/EX output register.
// Ports: clk, rst_n (async, active low), flush; fetch side in_valid/in_ready/
//   in_instr/in_pc; execute side out_valid/out_ready and registered out_*
//   decode fields; hazard_stall flags the load-use interlock (combinational).
package cpu_defs;
    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_BEQ = 4'd9;
    localparam logic [3:0] ALU_BNE = 4'd10;
    localparam logic [3:0] ALU_BLT = 4'd11;
    localparam logic [3:0] ALU_BGE = 4'd12;

    localparam logic [6:0] OPCODE_NOP   = 7'b0000000;
    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
    localparam logic [6:0] OPCODE_ITYPE = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;
    localparam logic [6:0] OPCODE_BTYPE = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR  = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
endpackage

module decode_stage
    import cpu_defs::*;
#(
    parameter int XLEN      = 32,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_alu_op,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_alu_src_imm,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_jalr,
    output logic            out_illegal,
    output logic            hazard_stall
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [4:0]  f_rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_sh;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign f_rs1  = in_instr[19:15];
    assign f_rs2  = in_instr[24:20];
    assign f_rd   = in_instr[11:7];

    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
    assign imm_sh = {27'd0, in_instr[24:20]};

    logic [3:0]  d_alu_op;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [4:0]  d_rd;
    logic [31:0] d_imm;
    logic        d_src_imm;
    logic        d_reg_write;
    logic        d_mem_read;
    logic        d_mem_write;
    logic        d_branch;
    logic        d_jump;
    logic        d_jalr;
    logic        d_illegal;

    always_comb begin
        d_alu_op    = ALU_NOP;
        d_rs1       = 5'd0;
        d_rs2       = 5'd0;
        d_rd        = 5'd0;
        d_imm       = 32'd0;
        d_src_imm   = 1'b0;
        d_reg_write = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_branch    = 1'b0;
        d_jump      = 1'b0;
        d_jalr      = 1'b0;
        d_illegal   = 1'b0;

        case (opcode)
            OPCODE_RTYPE: begin
                d_rs1       = f_rs1;
                d_rs2       = f_rs2;
                d_rd        = f_rd;
                d_reg_write = 1'b1;
                unique case (1'b1)
                    (funct7 == F7_BASE && funct3 == 3'b000): d_alu_op = ALU_ADD;
                    (funct7 == F7_ALT  && funct3 == 3'b000): d_alu_op = ALU_SUB;
                    (funct7 == F7_BASE && funct3 == 3'b100): d_alu_op = ALU_XOR;
                    (funct7 == F7_BASE && funct3 == 3'b110): d_alu_op = ALU_OR;
                    (funct7 == F7_BASE && funct3 == 3'b111): d_alu_op = ALU_AND;
                    (funct7 == F7_BASE && funct3 == 3'b001): d_alu_op = ALU_SLL;
                    (funct7 == F7_BASE && funct3 == 3'b101): d_alu_op = ALU_SRL;
                    (funct7 == F7_ALT  && funct3 == 3'b101): d_alu_op = ALU_SRA;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPCODE_ITYPE: begin
                d_rs1       = f_rs1;
                d_rd        = f_rd;
                d_reg_write = 1'b1;
                d_src_imm   = 1'b1;
                d_imm       = imm_i;
                unique case (1'b1)
                    (funct3 == 3'b000): d_alu_op = ALU_ADD;
                    (funct3 == 3'b100): d_alu_op = ALU_XOR;
                    (funct3 == 3'b110): d_alu_op = ALU_OR;
                    (funct3 == 3'b111): d_alu_op = ALU_AND;
                    (funct3 == 3'b001 && funct7 == F7_BASE): begin
                        d_alu_op = ALU_SLL;
                        d_imm    = imm_sh;
                    end
                    (funct3 == 3'b101 && funct7 == F7_BASE): begin
                        d_alu_op = ALU_SRL;
                        d_imm    = imm_sh;
                    end
                    (funct3 == 3'b101 && funct7 == F7_ALT): begin
                        d_alu_op = ALU_SRA;
                        d_imm    = imm_sh;
                    end
                    default: d_illegal = 1'b1;
                endcase
            end
            OPCODE_LOAD: begin
                d_rs1       = f_rs1;
                d_rd        = f_rd;
                d_alu_op    = ALU_ADD;
                d_imm       = imm_i;
                d_src_imm   = 1'b1;
                d_mem_read  = 1'b1;
                d_reg_write = 1'b1;
            end
            OPCODE_STORE: begin
                d_rs1       = f_rs1;
                d_rs2       = f_rs2;
                d_alu_op    = ALU_ADD;
                d_imm       = imm_s;
                d_src_imm   = 1'b1;
                d_mem_write = 1'b1;
            end
            OPCODE_BTYPE: begin
                d_rs1    = f_rs1;
                d_rs2    = f_rs2;
                d_imm    = imm_b;
                d_branch = 1'b1;
                unique case (1'b1)
                    (funct3 == 3'b000): d_alu_op = ALU_BEQ;
                    (funct3 == 3'b001): d_alu_op = ALU_BNE;
                    (funct3 == 3'b100): d_alu_op = ALU_BLT;
                    (funct3 == 3'b101): d_alu_op = ALU_BGE;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPCODE_JAL: begin
                d_rd        = f_rd;
                d_alu_op    = ALU_ADD;
                d_imm       = imm_j;
                d_src_imm   = 1'b1;
                d_jump      = 1'b1;
                d_reg_write = 1'b1;
            end
            OPCODE_JALR: begin
                d_rs1       = f_rs1;
                d_rd        = f_rd;
                d_alu_op    = ALU_ADD;
                d_imm       = imm_i;
                d_src_imm   = 1'b1;
                d_jump      = 1'b1;
                d_jalr      = 1'b1;
                d_reg_write = 1'b1;
            end
            OPCODE_NOP: ;
            default: d_illegal = 1'b1;
        endcase

        // An illegal item carries no operands and no side effects.
        if (d_illegal) begin
            d_alu_op    = ALU_NOP;
            d_rs1       = 5'd0;
            d_rs2       = 5'd0;
            d_rd        = 5'd0;
            d_imm       = 32'd0;
            d_src_imm   = 1'b0;
            d_reg_write = 1'b0;
            d_mem_read  = 1'b0;
            d_mem_write = 1'b0;
            d_branch    = 1'b0;
            d_jump      = 1'b0;
            d_jalr      = 1'b0;
        end
        if (d_rd == 5'd0) begin
            d_reg_write = 1'b0;
        end
    end

    // Unused source fields decode to 0, and out_rd != 0 keeps x0 out.
    assign hazard_stall = HAZARD_EN && out_valid && out_mem_read &&
                          (out_rd != 5'd0) && in_valid &&
                          ((out_rd == d_rs1) || (out_rd == d_rs2));

    assign in_ready = !flush && !hazard_stall && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_pc          <= '0;
            out_alu_op      <= ALU_NOP;
            out_funct3      <= 3'd0;
            out_rs1         <= 5'd0;
            out_rs2         <= 5'd0;
            out_rd          <= 5'd0;
            out_imm         <= '0;
            out_alu_src_imm <= 1'b0;
            out_reg_write   <= 1'b0;
            out_mem_read    <= 1'b0;
            out_mem_write   <= 1'b0;
            out_branch      <= 1'b0;
            out_jump        <= 1'b0;
            out_jalr        <= 1'b0;
            out_illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid       <= 1'b1;
            out_pc          <= in_pc;
            out_alu_op      <= d_alu_op;
            out_funct3      <= funct3;
            out_rs1         <= d_rs1;
            out_rs2         <= d_rs2;
            out_rd          <= d_rd;
            out_imm         <= XLEN'($signed(d_imm));
            out_alu_src_imm <= d_src_imm;
            out_reg_write   <= d_reg_write;
            out_mem_read    <= d_mem_read;
            out_mem_write   <= d_mem_write;
            out_branch      <= d_branch;
            out_jump        <= d_jump;
            out_jalr        <= d_jalr;
            out_illegal     <= d_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against
// a format-table decode model and a one-slot handshake model.
module tb_decode_stage;
    import cpu_defs::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [3:0]  out_alu_op;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic        out_alu_src_imm;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_branch;
    logic        out_jump;
    logic        out_jalr;
    logic        out_illegal;
    logic        hazard_stall;

    decode_stage #(.XLEN(32), .HAZARD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_alu_op(out_alu_op),
        .out_funct3(out_funct3), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_alu_src_imm(out_alu_src_imm),
        .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write),
        .out_branch(out_branch), .out_jump(out_jump),
        .out_jalr(out_jalr), .out_illegal(out_illegal),
        .hazard_stall(hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        simm;
        logic        wr;
        logic        mr;
        logic        mw;
        logic        br;
        logic        j;
        logic        jr;
        logic        ill;
    } dec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic dec_t model(input logic [31:0] w, input logic [31:0] pc);
        dec_t d;
        int sx;
        logic [2:0] f3;
        logic [6:0] f7;
        logic is_r, is_i, is_l, is_s, is_b, is_jal, is_jalr, is_nop;
        d = '0;
        d.pc = pc;
        d.f3 = w[14:12];
        f3 = w[14:12];
        f7 = w[31:25];
        sx = $signed(w);
        is_r    = (w[6:0] == OPCODE_RTYPE);
        is_i    = (w[6:0] == OPCODE_ITYPE);
        is_l    = (w[6:0] == OPCODE_LOAD);
        is_s    = (w[6:0] == OPCODE_STORE);
        is_b    = (w[6:0] == OPCODE_BTYPE);
        is_jal  = (w[6:0] == OPCODE_JAL);
        is_jalr = (w[6:0] == OPCODE_JALR);
        is_nop  = (w[6:0] == OPCODE_NOP);
        if (is_r | is_i | is_l | is_s | is_b | is_jalr) d.rs1 = w[19:15];
        if (is_r | is_s | is_b) d.rs2 = w[24:20];
        if (is_r | is_i | is_l | is_jal | is_jalr) d.rd = w[11:7];
        if (is_i | is_l | is_jalr) d.imm = sx >>> 20;
        if (is_s) d.imm = ((sx >>> 25) <<< 5) | int'(w[11:7]);
        if (is_b) d.imm = ((sx >>> 31) <<< 12) + int'(w[7]) * 2048
                          + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (is_jal) d.imm = ((sx >>> 31) <<< 20) + int'(w[19:12]) * 4096
                            + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        d.simm = is_i | is_l | is_s | is_jal | is_jalr;
        d.wr   = is_r | is_i | is_l | is_jal | is_jalr;
        d.mr   = is_l;
        d.mw   = is_s;
        d.br   = is_b;
        d.j    = is_jal | is_jalr;
        d.jr   = is_jalr;
        d.op   = ALU_NOP;
        if (is_l | is_s | is_jal | is_jalr) d.op = ALU_ADD;
        d.ill = !(is_r | is_i | is_l | is_s | is_b | is_jal | is_jalr | is_nop);
        if (is_r) begin
            case ({f7, f3})
                {7'h00, 3'd0}: d.op = ALU_ADD;
                {7'h20, 3'd0}: d.op = ALU_SUB;
                {7'h00, 3'd4}: d.op = ALU_XOR;
                {7'h00, 3'd6}: d.op = ALU_OR;
                {7'h00, 3'd7}: d.op = ALU_AND;
                {7'h00, 3'd1}: d.op = ALU_SLL;
                {7'h00, 3'd5}: d.op = ALU_SRL;
                {7'h20, 3'd5}: d.op = ALU_SRA;
                default:       d.ill = 1'b1;
            endcase
        end
        if (is_i) begin
            case (f3)
                3'd0: d.op = ALU_ADD;
                3'd4: d.op = ALU_XOR;
                3'd6: d.op = ALU_OR;
                3'd7: d.op = ALU_AND;
                3'd1: if (f7 == 7'h00) d.op = ALU_SLL; else d.ill = 1'b1;
                3'd5: begin
                    if (f7 == 7'h00) d.op = ALU_SRL;
                    else if (f7 == 7'h20) d.op = ALU_SRA;
                    else d.ill = 1'b1;
                end
                default: d.ill = 1'b1;
            endcase
            if (f3 == 3'd1 || f3 == 3'd5) d.imm = int'(w[24:20]);
        end
        if (is_b) begin
            case (f3)
                3'd0: d.op = ALU_BEQ;
                3'd1: d.op = ALU_BNE;
                3'd4: d.op = ALU_BLT;
                3'd5: d.op = ALU_BGE;
                default: d.ill = 1'b1;
            endcase
        end
        if (d.ill) begin
            d = '0;
            d.pc  = pc;
            d.f3  = w[14:12];
            d.ill = 1'b1;
            d.op  = ALU_NOP;
        end
        if (d.rd == 5'd0) d.wr = 1'b0;
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  opc [8];
        int k;
        opc[0] = OPCODE_RTYPE;
        opc[1] = OPCODE_ITYPE;
        opc[2] = OPCODE_LOAD;
        opc[3] = OPCODE_STORE;
        opc[4] = OPCODE_BTYPE;
        opc[5] = OPCODE_JAL;
        opc[6] = OPCODE_JALR;
        opc[7] = OPCODE_NOP;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 8) begin
            w[6:0]   = opc[k];
            w[11:7]  = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: ;
            endcase
        end
        return w;
    endfunction

    logic m_valid = 1'b0;
    dec_t m_item = '0;

    // Cycle-level reference: one holding slot, checked every falling edge.
    always @(negedge clk) begin
        dec_t inc;
        logic stall;
        logic rdy;
        if (!rst_n) m_valid = 1'b0;
        inc = model(in_instr, in_pc);
        stall = m_valid && m_item.mr && (m_item.rd != 5'd0) && in_valid &&
                (m_item.rd == inc.rs1 || m_item.rd == inc.rs2);
        rdy = !flush && !stall && (!m_valid || out_ready);
        chk("out_valid", out_valid, m_valid);
        chk("hazard_stall", hazard_stall, stall);
        chk("in_ready", in_ready, rdy);
        if (m_valid) begin
            chk("pc", out_pc, m_item.pc);
            chk("alu_op", out_alu_op, m_item.op);
            chk("funct3", out_funct3, m_item.f3);
            chk("regs", {out_rs1, out_rs2, out_rd},
                {m_item.rs1, m_item.rs2, m_item.rd});
            chk("imm", out_imm, m_item.imm);
            chk("ctrl", {out_alu_src_imm, out_reg_write, out_mem_read,
                         out_mem_write, out_branch, out_jump, out_jalr,
                         out_illegal},
                {m_item.simm, m_item.wr, m_item.mr, m_item.mw,
                 m_item.br, m_item.j, m_item.jr, m_item.ill});
        end
        if (rst_n) begin
            if (flush) m_valid = 1'b0;
            else if (in_valid && rdy) begin
                m_valid = 1'b1;
                m_item  = inc;
            end else if (out_ready) m_valid = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_instr = 32'd0;
        in_pc = 32'd0;
        out_ready = 1'b0;
        repeat (2) step();
        chk("rst_valid", out_valid, 0);
        chk("rst_alu_op", out_alu_op, ALU_NOP);
        chk("rst_imm", out_imm, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        in_pc = 32'h100;
        step();
        chk("add_op", out_alu_op, ALU_ADD);
        chk("add_regs", {out_rs1, out_rs2, out_rd}, {5'd1, 5'd2, 5'd3});
        chk("add_wr", out_reg_write, 1);
        in_instr = 32'h402081B3;
        in_pc = 32'h104;
        step();
        chk("sub_op", out_alu_op, ALU_SUB);
        chk("sub_regs", {out_rs1, out_rs2, out_rd}, {5'd1, 5'd2, 5'd3});

        in_instr = 32'h4030D213;
        in_pc = 32'h108;
        step();
        chk("srai_op", out_alu_op, ALU_SRA);
        chk("srai_imm", out_imm, 3);
        chk("srai_src", out_alu_src_imm, 1);
        in_instr = 32'h00208463;
        in_pc = 32'h10C;
        step();
        chk("beq_op", out_alu_op, ALU_BEQ);
        chk("beq_imm", out_imm, 8);
        chk("beq_branch", out_branch, 1);
        chk("beq_rd", out_rd, 0);

        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_op", out_alu_op, ALU_NOP);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);

        in_valid = 1'b1;
        in_instr = 32'h0000A283;
        in_pc = 32'h200;
        step();
        in_instr = 32'h00228333;
        in_pc = 32'h204;
        #1;
        chk("lu_stall", hazard_stall, 1);
        chk("lu_in_ready", in_ready, 0);
        step();
        chk("lu_bubble", out_valid, 0);
        chk("lu_in_ready2", in_ready, 1);
        step();
        chk("lu_add_valid", out_valid, 1);
        chk("lu_add_rd", out_rd, 6);
        chk("lu_add_rs1", out_rs1, 5);

        in_instr = 32'h0020C1B3;
        in_pc = 32'h300;
        step();
        out_ready = 1'b0;
        in_instr = 32'h00000013;
        in_pc = 32'h304;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_valid", out_valid, 1);
            chk("hold_op", out_alu_op, ALU_XOR);
            chk("hold_pc", out_pc, 32'h300);
            chk("hold_in_ready", in_ready, 0);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        out_ready = 1'b1;
        step();
        chk("flush_lost", out_valid, 0);

        in_valid = 1'b1;
        in_instr = 32'hFFFFFFFF;
        in_pc = 32'h400;
        step();
        chk("ill_flag", out_illegal, 1);
        chk("ill_op", out_alu_op, ALU_NOP);
        chk("ill_ctrl", {out_reg_write, out_mem_read, out_mem_write,
                         out_branch, out_jump, out_jalr}, 0);
        for (int k = 0; k < 8; k++) begin
            in_instr = 32'h00000093 | (32'(k) << 20);
            in_pc = 32'h500 + 32'(4 * k);
            step();
            chk("tp_valid", out_valid, 1);
            chk("tp_pc", out_pc, 32'h500 + 32'(4 * k));
            chk("tp_imm", out_imm, 32'(k));
        end

        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = rand_instr();
            in_pc = $urandom & 32'hFFFF_FFFC;
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            rst_n = 1'b1;
            if (i == 1500) begin
                #1 rst_n = 1'b0;
            end
            step();
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
